montgomery_reduce_scheduler: RTL and testbench
==============================================

// Module: montgomery_reduce_scheduler
// PURPOSE
//  Shares one montgomery_reduce datapath between two requesters (e.g. two modexp squaring/multiply
//  streams). Round-robin arbitrates a whole reduction job and muxes the granted T stream into the reducer.
//  Drives k / N constant-ROM block addresses from the reducer's consumed pulses.
//  Routes t result blocks back to the owner and signals job completion.
// PARAMETERS
//  REGISTER_SIZE  32    bits per block
//  NUM_BLOCKS     256   T blocks per job (T = REGISTER_SIZE*NUM_BLOCKS bits)
//  R              4096  Montgomery radix bits; CONST_BLOCKS = R/REGISTER_SIZE (128)
//  OUT_BLOCKS     NUM_BLOCKS-R/REGISTER_SIZE (128)  result blocks expected per job
// PORTS
//  clk_in              in   1      clock
//  rst_in              in   1      reset, asynchronous, active-low
//  req_in              in   2      per-requester job request, level, held until grant
//  grant_out           out  2      one-hot owner of the reducer; 0 when idle
//  block_valid_in      in   2      per-requester T block strobe (honoured only when granted)
//  block0_in/block1_in in   RS     T block data, LSB block first
//  red_valid_out       out  1      T block strobe to reducer valid_in
//  red_block_out       out  RS     T block to reducer T_block_in
//  consumed_k_in       in   1      reducer consumed_k_out
//  consumed_N_in       in   1      reducer consumed_N_out
//  k_addr_out          out  clog2(CONST_BLOCKS)  k constant-ROM block index
//  n_addr_out          out  clog2(CONST_BLOCKS)  N constant-ROM block index
//  red_res_valid_in    in   1      reducer result strobe
//  red_res_block_in    in   RS     reducer result block
//  res_valid_out       out  2      result strobe to owner (one-hot)
//  res_block_out       out  RS     result block
//  done_out            out  2      1-cycle pulse to owner at job end
//  busy_out            out  1      high in any state but IDLE
//  err_out             out  1      sticky protocol error
// BEHAVIOUR
//  Reset (rst_in low, async): all outputs 0, state IDLE, counters/addresses 0, rr pointer -> req 0 first.
//  FSM IDLE -> STREAM -> DRAIN -> DONE -> IDLE.
//  IDLE: if any req_in, next cycle grant_out one-hot, state STREAM, stream/result counts and k/n addr
//   cleared. Both requesting: grant the one not served last (round-robin); single: grant it.
//  STREAM: granted block_valid_in registered onto red_valid_out/red_block_out, latency 1 cycle.
//   Stream count increments per accepted block; after NUM_BLOCKS-th -> DRAIN.
//  Non-granted block_valid_in always ignored (no err; requester may be preloading).
//  DRAIN: granted block_valid_in sets err_out and is dropped.
//  Result routing in STREAM and DRAIN: red_res_valid_in registered to res_valid_out[owner]
//   with data, latency 1; result count increments.
//  DRAIN -> DONE when result count == OUT_BLOCKS (including the same-cycle arrival).
//  Results arriving in STREAM are counted; if count reaches OUT_BLOCKS before stream ends, stay STREAM.
//  DONE: done_out[owner] high 1 cycle, grant_out cleared, rr pointer updated, -> IDLE.
//   New grant earliest next cycle.
//  red_res_valid_in in IDLE/DONE, or beyond OUT_BLOCKS: sets err_out, not forwarded.
//  k_addr_out: +1 per consumed_k_in; wraps CONST_BLOCKS-1 -> 0. n_addr_out: same on consumed_N_in.
//   Both pulses in one cycle advance both independently.
//  Counters are wide enough for NUM_BLOCKS and never wrap inside a job.
//  err_out clears only on reset. req_in drop while granted does not abort the job.
//  Reset mid-job: immediate return to IDLE, all outputs 0, no done.
// TESTING
//  Req0 only, 256 blocks 0..255, reducer model returns 128 blocks -> red_block_out = in delayed 1 cycle;
//   done_out=01 once; err_out=0.
//  Req0 and req1 same cycle, twice -> grant order 01,10,01,10; no overlap; done pulses match owner.
//  130 consumed_k_in pulses -> k_addr_out 0..127,0,1; 5 simultaneous k/N pulses -> both addr +5.
//  Extra 257th block in DRAIN, or result in IDLE -> err_out=1 sticky, nothing forwarded.
//  rst_in low mid-STREAM at block 100 -> outputs 0 asynchronously; new req -> clean job, counts from 0.
//  All 128 results arrive during STREAM -> stays STREAM to block 256, then DONE directly.

Source files
------------

// File: rtl/montgomery_reduce_scheduler.sv
// rtl/montgomery_reduce_scheduler.sv - round-robin share of one montgomery_reduce datapath between two requesters
module montgomery_reduce_scheduler #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 256,
  parameter int R             = 4096,
  localparam int CONST_BLOCKS = R / REGISTER_SIZE,
  localparam int OUT_BLOCKS   = NUM_BLOCKS - CONST_BLOCKS,
  localparam int AW           = $clog2(CONST_BLOCKS),
  localparam int CW           = $clog2(NUM_BLOCKS + 1)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [1:0]               req_in,
  output logic [1:0]               grant_out,
  input  logic [1:0]               block_valid_in,
  input  logic [REGISTER_SIZE-1:0] block0_in,
  input  logic [REGISTER_SIZE-1:0] block1_in,
  output logic                     red_valid_out,
  output logic [REGISTER_SIZE-1:0] red_block_out,
  input  logic                     consumed_k_in,
  input  logic                     consumed_N_in,
  output logic [AW-1:0]            k_addr_out,
  output logic [AW-1:0]            n_addr_out,
  input  logic                     red_res_valid_in,
  input  logic [REGISTER_SIZE-1:0] red_res_block_in,
  output logic [1:0]               res_valid_out,
  output logic [REGISTER_SIZE-1:0] res_block_out,
  output logic [1:0]               done_out,
  output logic                     busy_out,
  output logic                     err_out
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  localparam logic [CW-1:0] LAST_BLK  = CW'(NUM_BLOCKS - 1);
  localparam logic [CW-1:0] OUT_CNT   = CW'(OUT_BLOCKS);
  localparam logic [CW-1:0] OUT_LAST  = CW'(OUT_BLOCKS - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(CONST_BLOCKS - 1);

  state_t                   r_state;
  logic                     r_owner;
  logic                     r_rr_next;
  logic [1:0]               r_grant;
  logic [CW-1:0]            r_stream_cnt;
  logic [CW-1:0]            r_res_cnt;
  logic [AW-1:0]            r_k_addr;
  logic [AW-1:0]            r_n_addr;
  logic                     r_red_valid;
  logic [REGISTER_SIZE-1:0] r_red_block;
  logic [1:0]               r_res_valid;
  logic [REGISTER_SIZE-1:0] r_res_block;
  logic [1:0]               r_done;
  logic                     r_err;

  logic                     w_blk_v;
  logic [REGISTER_SIZE-1:0] w_blk;
  logic                     w_active;
  logic                     w_res_ok;
  logic                     w_res_bad;
  logic                     w_res_full;
  logic                     w_last_blk;
  logic                     w_pick;

  assign w_blk_v    = r_owner ? block_valid_in[1] : block_valid_in[0];
  assign w_blk      = r_owner ? block1_in : block0_in;
  assign w_active   = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign w_res_ok   = w_active && red_res_valid_in && (r_res_cnt < OUT_CNT);
  assign w_res_bad  = red_res_valid_in && !w_res_ok;
  // Counts the result arriving this cycle so the job can close without an extra DRAIN cycle.
  assign w_res_full = (r_res_cnt == OUT_CNT) || (w_res_ok && (r_res_cnt == OUT_LAST));
  assign w_last_blk = (r_state == S_STREAM) && w_blk_v && (r_stream_cnt == LAST_BLK);
  assign w_pick     = (req_in == 2'b11) ? r_rr_next : req_in[1];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_rr_next    <= 1'b0;
      r_grant      <= 2'b00;
      r_stream_cnt <= '0;
      r_res_cnt    <= '0;
      r_k_addr     <= '0;
      r_n_addr     <= '0;
      r_red_valid  <= 1'b0;
      r_red_block  <= '0;
      r_res_valid  <= 2'b00;
      r_res_block  <= '0;
      r_done       <= 2'b00;
      r_err        <= 1'b0;
    end else begin
      r_red_valid <= 1'b0;
      r_res_valid <= 2'b00;
      r_done      <= 2'b00;
      if (consumed_k_in) r_k_addr <= (r_k_addr == ADDR_LAST) ? '0 : r_k_addr + AW'(1);
      if (consumed_N_in) r_n_addr <= (r_n_addr == ADDR_LAST) ? '0 : r_n_addr + AW'(1);
      if (w_res_bad) r_err <= 1'b1;
      if (w_res_ok) begin
        r_res_valid <= r_owner ? 2'b10 : 2'b01;
        r_res_block <= red_res_block_in;
        r_res_cnt   <= r_res_cnt + CW'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (|req_in) begin
            r_owner      <= w_pick;
            r_grant      <= w_pick ? 2'b10 : 2'b01;
            r_stream_cnt <= '0;
            r_res_cnt    <= '0;
            r_k_addr     <= '0;
            r_n_addr     <= '0;
            r_state      <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_blk_v) begin
            r_red_valid  <= 1'b1;
            r_red_block  <= w_blk;
            r_stream_cnt <= r_stream_cnt + CW'(1);
          end
          if (w_last_blk) begin
            if (w_res_full) begin
              r_done  <= r_grant;
              r_grant <= 2'b00;
              r_state <= S_DONE;
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_blk_v) r_err <= 1'b1;
          if (w_res_full) begin
            r_done  <= r_grant;
            r_grant <= 2'b00;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_rr_next <= ~r_owner;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign grant_out     = r_grant;
  assign red_valid_out = r_red_valid;
  assign red_block_out = r_red_block;
  assign k_addr_out    = r_k_addr;
  assign n_addr_out    = r_n_addr;
  assign res_valid_out = r_res_valid;
  assign res_block_out = r_res_block;
  assign done_out      = r_done;
  assign busy_out      = (r_state != S_IDLE);
  assign err_out       = r_err;

endmodule

// File: tb/tb_montgomery_reduce_scheduler.sv
// tb/tb_montgomery_reduce_scheduler.sv - directed scoreboard bench for montgomery_reduce_scheduler
module tb_montgomery_reduce_scheduler;
  localparam int RS = 32;
  localparam int NB = 256;
  localparam int OB = 128;
  localparam int CB = 128;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [1:0]    req_in;
  logic [1:0]    grant_out;
  logic [1:0]    block_valid_in;
  logic [RS-1:0] block0_in, block1_in;
  logic          red_valid_out;
  logic [RS-1:0] red_block_out;
  logic          consumed_k_in, consumed_N_in;
  logic [6:0]    k_addr_out, n_addr_out;
  logic          red_res_valid_in;
  logic [RS-1:0] red_res_block_in;
  logic [1:0]    res_valid_out;
  logic [RS-1:0] res_block_out;
  logic [1:0]    done_out;
  logic          busy_out, err_out;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  logic [RS-1:0] red_q[$];
  logic [RS+1:0] res_q[$];

  montgomery_reduce_scheduler dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .grant_out(grant_out),
    .block_valid_in(block_valid_in), .block0_in(block0_in), .block1_in(block1_in),
    .red_valid_out(red_valid_out), .red_block_out(red_block_out),
    .consumed_k_in(consumed_k_in), .consumed_N_in(consumed_N_in),
    .k_addr_out(k_addr_out), .n_addr_out(n_addr_out),
    .red_res_valid_in(red_res_valid_in), .red_res_block_in(red_res_block_in),
    .res_valid_out(res_valid_out), .res_block_out(res_block_out),
    .done_out(done_out), .busy_out(busy_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (rst_in) begin
      if (red_valid_out) begin
        if (red_q.size() == 0) chk("red_unexpected", 64'(red_block_out), 64'hDEAD);
        else chk("red_block", 64'(red_block_out), 64'(red_q.pop_front()));
      end
      if (res_valid_out != 2'b00) begin
        if (res_q.size() == 0) chk("res_unexpected", 64'({res_valid_out, res_block_out}), 64'hDEAD);
        else chk("res_block", 64'({res_valid_out, res_block_out}), 64'(res_q.pop_front()));
      end
      if (done_out != 2'b00) done_cnt++;
      chk("grant_onehot0", 64'($onehot0(grant_out)), 64'd1);
    end
  end

  task automatic idle_inputs();
    req_in = 2'b00; block_valid_in = 2'b00; block0_in = '0; block1_in = '0;
    consumed_k_in = 1'b0; consumed_N_in = 1'b0;
    red_res_valid_in = 1'b0; red_res_block_in = '0;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    idle_inputs();
    red_q.delete();
    res_q.delete();
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;
  endtask

  task automatic run_job(input logic [1:0] req, input logic [1:0] exp_grant, input bit early,
                         input bit extra, input int base, input int abort_at);
    logic own;
    logic [RS-1:0] d;
    req_in = req;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_in); #1;
      if (grant_out != 2'b00) break;
    end
    chk("grant", 64'(grant_out), 64'(exp_grant));
    req_in = 2'b00;
    if (grant_out == 2'b00) return;
    own = grant_out[1];
    for (int i = 0; i < NB; i++) begin
      if (early && i == OB) begin
        chk("stay_stream_busy", 64'(busy_out), 64'd1);
        chk("stay_stream_nodone", 64'(done_out), 64'd0);
      end
      d = RS'(base + i);
      block_valid_in = 2'b11;
      block0_in = own ? ~d : d;
      block1_in = own ? d : ~d;
      red_q.push_back(d);
      red_res_valid_in = early && (i < OB);
      red_res_block_in = RS'(base + 32'h5000 + i);
      if (early && i < OB) res_q.push_back({exp_grant, red_res_block_in});
      if (i == abort_at) begin
        #2 rst_in = 1'b0;
        red_q.delete();
        res_q.delete();
        #1;
        chk("abort_grant", 64'(grant_out), 64'd0);
        chk("abort_red_valid", 64'(red_valid_out), 64'd0);
        chk("abort_busy", 64'(busy_out), 64'd0);
        chk("abort_done", 64'(done_out), 64'd0);
        idle_inputs();
        @(posedge clk_in); #1 rst_in = 1'b1;
        return;
      end
      @(posedge clk_in); #1;
    end
    block_valid_in = 2'b00;
    red_res_valid_in = 1'b0;
    if (!early) begin
      if (extra) begin
        block_valid_in = own ? 2'b10 : 2'b01;
        @(posedge clk_in); #1;
        block_valid_in = 2'b00;
        chk("err_extra_block", 64'(err_out), 64'd1);
      end
      for (int i = 0; i < OB; i++) begin
        red_res_valid_in = 1'b1;
        red_res_block_in = RS'(base + 32'h9000 + i);
        res_q.push_back({exp_grant, red_res_block_in});
        @(posedge clk_in); #1;
      end
      red_res_valid_in = 1'b0;
    end
    chk("done_pulse", 64'(done_out), 64'(exp_grant));
    chk("done_grant_clear", 64'(grant_out), 64'd0);
    @(posedge clk_in); #1;
    chk("done_once", 64'(done_out), 64'd0);
    chk("idle_busy", 64'(busy_out), 64'd0);
    @(posedge clk_in); #1;
  endtask

  initial begin
    do_reset();
    chk("rst_grant", 64'(grant_out), 64'd0);
    chk("rst_red_valid", 64'(red_valid_out), 64'd0);
    chk("rst_k_addr", 64'(k_addr_out), 64'd0);
    chk("rst_n_addr", 64'(n_addr_out), 64'd0);
    chk("rst_res_valid", 64'(res_valid_out), 64'd0);
    chk("rst_done", 64'(done_out), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_err", 64'(err_out), 64'd0);

    for (int i = 0; i < 130; i++) begin
      consumed_k_in = 1'b1;
      @(posedge clk_in); #1;
      chk("k_addr_wrap", 64'(k_addr_out), 64'((i + 1) % CB));
    end
    consumed_k_in = 1'b0;
    chk("n_addr_still", 64'(n_addr_out), 64'd0);
    repeat (5) begin
      consumed_k_in = 1'b1; consumed_N_in = 1'b1;
      @(posedge clk_in); #1;
    end
    consumed_k_in = 1'b0; consumed_N_in = 1'b0;
    chk("k_addr_both", 64'(k_addr_out), 64'd7);
    chk("n_addr_both", 64'(n_addr_out), 64'd5);

    run_job(2'b01, 2'b01, 1'b0, 1'b0, 0, -1);
    chk("err_clean_job", 64'(err_out), 64'd0);

    do_reset();
    run_job(2'b11, 2'b01, 1'b0, 1'b0, 32'h10000, -1);
    run_job(2'b11, 2'b10, 1'b1, 1'b0, 32'h20000, -1);
    run_job(2'b11, 2'b01, 1'b1, 1'b0, 32'h30000, -1);
    run_job(2'b11, 2'b10, 1'b0, 1'b0, 32'h40000, -1);
    chk("err_rr_jobs", 64'(err_out), 64'd0);

    run_job(2'b10, 2'b10, 1'b0, 1'b1, 32'h50000, -1);
    chk("err_sticky_job", 64'(err_out), 64'd1);

    do_reset();
    chk("err_cleared_rst", 64'(err_out), 64'd0);
    red_res_valid_in = 1'b1; red_res_block_in = 32'hABCD;
    @(posedge clk_in); #1;
    red_res_valid_in = 1'b0;
    chk("err_idle_result", 64'(err_out), 64'd1);
    chk("idle_result_dropped", 64'(res_valid_out), 64'd0);
    repeat (3) @(posedge clk_in); #1;
    chk("err_idle_sticky", 64'(err_out), 64'd1);

    do_reset();
    run_job(2'b01, 2'b01, 1'b0, 1'b0, 32'h60000, 100);
    chk("post_abort_k", 64'(k_addr_out), 64'd0);
    run_job(2'b01, 2'b01, 1'b1, 1'b0, 32'h70000, -1);
    chk("err_after_abort", 64'(err_out), 64'd0);

    @(posedge clk_in); #1;
    chk("red_queue_empty", 64'(red_q.size()), 64'd0);
    chk("res_queue_empty", 64'(res_q.size()), 64'd0);
    chk("done_count", 64'(done_cnt), 64'd7);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
